// File: rtl/imm_ext_arbiter_pkg.sv
// Shared types and constants for the immediate-extension arbiter.
package imm_ext_arbiter_pkg;

  // Width of the per-request immediate-type control field.
  localparam int IMM_CTRL_WIDTH = 3;

  // Immediate formats; codes 3'b101..3'b111 are reserved and flagged as errors.
  typedef enum logic [IMM_CTRL_WIDTH-1:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_type_t;

  // Response slot state: EMPTY means rsp_valid_o is low.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/imm_ext_arbiter_extend.sv
// Combinational RISC-V immediate extractor / sign extender. The raw field is
// instr[31:7], so imm_i[k] corresponds to instr[k+7]; imm_i[24] is the sign.
module extend_imm
  import imm_ext_arbiter_pkg::*;
#(
  parameter int IMM_WIDTH = 25,
  parameter int OUT_WIDTH = 64
) (
  input  logic [IMM_CTRL_WIDTH-1:0] ctrl_i,
  input  logic [IMM_WIDTH-1:0]      imm_i,
  output logic [OUT_WIDTH-1:0]      imm_o,
  output logic                      err_o
);

  logic sgn;
  assign sgn = imm_i[24];

  // Select the format-specific bit shuffle; reserved codes yield zero plus error.
  always_comb begin
    imm_o = '0;
    err_o = 1'b0;
    case (imm_type_t'(ctrl_i))
      IMM_I: imm_o = {{(OUT_WIDTH-12){sgn}}, imm_i[24:13]};
      IMM_S: imm_o = {{(OUT_WIDTH-12){sgn}}, imm_i[24:18], imm_i[4:0]};
      IMM_B: imm_o = {{(OUT_WIDTH-13){sgn}}, sgn, imm_i[0], imm_i[23:18],
                      imm_i[4:1], 1'b0};
      IMM_J: imm_o = {{(OUT_WIDTH-21){sgn}}, sgn, imm_i[12:5], imm_i[13],
                      imm_i[23:14], 1'b0};
      IMM_U: imm_o = {{(OUT_WIDTH-32){sgn}}, imm_i[24:5], 12'b0};
      default: err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter sharing one immediate extender between NUM_REQ
// requesters, with a single registered response slot tagged by winner id.
//
// Handshake semantics: a request transfers on a clock edge where
// req_valid_i[w] && req_ready_o[w]; the response transfers on an edge where
// rsp_valid_o && rsp_ready_i. Requesters keep valid and payload stable until
// accepted; the response slot holds its outputs stable while not consumed.
module imm_ext_arbiter
  import imm_ext_arbiter_pkg::*;
#(
  parameter int  NUM_REQ   = 2,
  parameter int  IMM_WIDTH = 25,
  parameter int  OUT_WIDTH = 64,
  parameter int  TAG_WIDTH = 5,
  parameter int  CNT_WIDTH = 16,
  localparam int ID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                    clk_i,
  input  logic                                    arst_ni,
  input  logic                                    flush_i,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  output logic [NUM_REQ-1:0]                      req_ready_o,
  input  logic [NUM_REQ-1:0][IMM_CTRL_WIDTH-1:0]  req_ctrl_i,
  input  logic [NUM_REQ-1:0][IMM_WIDTH-1:0]       req_imm_i,
  input  logic [NUM_REQ-1:0][TAG_WIDTH-1:0]       req_tag_i,
  output logic                                    rsp_valid_o,
  input  logic                                    rsp_ready_i,
  output logic [ID_WIDTH-1:0]                     rsp_id_o,
  output logic [TAG_WIDTH-1:0]                    rsp_tag_o,
  output logic [OUT_WIDTH-1:0]                    rsp_imm_o,
  output logic                                    rsp_err_o,
  output logic [CNT_WIDTH-1:0]                    conflict_cnt_o
);

  slot_state_t          slot_q, slot_d;
  logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]  rsp_id_q, rsp_id_d;
  logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;
  logic [OUT_WIDTH-1:0] rsp_imm_q, rsp_imm_d;
  logic                 rsp_err_q, rsp_err_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 win_valid;
  logic [ID_WIDTH-1:0]  win_id;
  logic                 found_hi, found_any;
  logic [ID_WIDTH-1:0]  id_hi, id_any;
  logic [NUM_REQ-1:0]   vld_shift;
  logic                 accept;
  logic                 hs;
  logic                 multi_req;
  logic [OUT_WIDTH-1:0] ext_imm;
  logic                 ext_err;

  // Round-robin pick: lowest valid index above rr_ptr, else lowest valid overall.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    id_hi     = '0;
    id_any    = '0;
    vld_shift = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      vld_shift = req_valid_i >> i;
      if (vld_shift[0]) begin
        if (!found_any) begin
          found_any = 1'b1;
          id_any    = ID_WIDTH'(i);
        end
        if (!found_hi && (ID_WIDTH'(i) > rr_ptr_q)) begin
          found_hi = 1'b1;
          id_hi    = ID_WIDTH'(i);
        end
      end
    end
    win_valid = found_any;
    win_id    = found_hi ? id_hi : id_any;
  end

  // The slot can take a new result when it is empty or is draining this cycle.
  assign accept    = !flush_i && ((slot_q == SLOT_EMPTY) || rsp_ready_i);
  assign hs        = win_valid && accept && arst_ni;
  assign multi_req = |(req_valid_i & (req_valid_i - NUM_REQ'(1)));

  // One-hot ready to the winner only; low throughout reset.
  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[win_id] = 1'b1;
  end

  extend_imm #(
    .IMM_WIDTH (IMM_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_extend_imm (
    .ctrl_i (req_ctrl_i[win_id]),
    .imm_i  (req_imm_i[win_id]),
    .imm_o  (ext_imm),
    .err_o  (ext_err)
  );

  // Slot next state: flush empties, a grant fills, consumption without a grant empties.
  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      slot_d = SLOT_EMPTY;
    end else if (hs) begin
      slot_d = SLOT_FULL;
    end else if ((slot_q == SLOT_FULL) && rsp_ready_i) begin
      slot_d = SLOT_EMPTY;
    end
  end

  // Payload, pointer and contention counter update only on a request handshake.
  always_comb begin
    rsp_id_d  = rsp_id_q;
    rsp_tag_d = rsp_tag_q;
    rsp_imm_d = rsp_imm_q;
    rsp_err_d = rsp_err_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    if (hs) begin
      rsp_id_d  = win_id;
      rsp_tag_d = req_tag_i[win_id];
      rsp_imm_d = ext_imm;
      rsp_err_d = ext_err;
      rr_ptr_d  = win_id;
      if (multi_req && !(&cnt_q)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State registers; rr_ptr resets to the last index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      slot_q    <= SLOT_EMPTY;
      rr_ptr_q  <= ID_WIDTH'(NUM_REQ - 1);
      rsp_id_q  <= '0;
      rsp_tag_q <= '0;
      rsp_imm_q <= '0;
      rsp_err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      slot_q    <= slot_d;
      rr_ptr_q  <= rr_ptr_d;
      rsp_id_q  <= rsp_id_d;
      rsp_tag_q <= rsp_tag_d;
      rsp_imm_q <= rsp_imm_d;
      rsp_err_q <= rsp_err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rsp_valid_o    = (slot_q == SLOT_FULL);
  assign rsp_id_o       = rsp_id_q;
  assign rsp_tag_o      = rsp_tag_q;
  assign rsp_imm_o      = rsp_imm_q;
  assign rsp_err_o      = rsp_err_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench for imm_ext_arbiter with a queue-based response scoreboard.
module tb_imm_ext_arbiter;

  localparam int EW = 1 + 5 + 64 + 1;

  logic             clk;
  logic             arst_n;
  logic             flush;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][2:0]  req_ctrl;
  logic [1:0][24:0] req_imm;
  logic [1:0][4:0]  req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [0:0]       rsp_id;
  logic [4:0]       rsp_tag;
  logic [63:0]      rsp_imm;
  logic             rsp_err;
  logic [15:0]      conflict_cnt;

  logic [EW-1:0]    exp_q[$];
  int               total;
  int               bad;
  bit               mon_en;

  imm_ext_arbiter dut (
    .clk_i          (clk),
    .arst_ni        (arst_n),
    .flush_i        (flush),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_ctrl_i     (req_ctrl),
    .req_imm_i      (req_imm),
    .req_tag_i      (req_tag),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_id_o       (rsp_id),
    .rsp_tag_o      (rsp_tag),
    .rsp_imm_o      (rsp_imm),
    .rsp_err_o      (rsp_err),
    .conflict_cnt_o (conflict_cnt)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_rsp(input logic id, input logic [4:0] t,
                                             input logic [63:0] im, input logic e);
    return {id, t, im, e};
  endfunction

  // monitor: pops on consumed responses, discards on flush
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] act_v;
    if (mon_en && arst_n && rsp_valid) begin
      if (flush) begin
        if (exp_q.size() > 0) exp_v = exp_q.pop_front();
      end else if (rsp_ready) begin
        total++;
        act_v = {rsp_id, rsp_tag, rsp_imm, rsp_err};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got id=%0d tag=%0h imm=%h err=%0d", rsp_id, rsp_tag, rsp_imm, rsp_err);
        end else begin
          exp_v = exp_q.pop_front();
          if (act_v !== exp_v) begin
            bad++;
            $display("FAIL rsp_data: got id=%0d tag=%0h imm=%h err=%0d expected id=%0d tag=%0h imm=%h err=%0d",
                     rsp_id, rsp_tag, rsp_imm, rsp_err,
                     exp_v[EW-1], exp_v[EW-2:EW-6], exp_v[64:1], exp_v[0]);
          end
        end
      end
    end
  end

  // driver: single request from requester r, waits for its ready (bounded)
  task automatic send(input logic r, input logic [2:0] c, input logic [24:0] im,
                      input logic [4:0] t, input logic [63:0] eimm, input logic eerr);
    int n;
    bit got;
    exp_q.push_back(pack_rsp(r, t, eimm, eerr));
    req_ctrl[r]  = c;
    req_imm[r]   = im;
    req_tag[r]   = t;
    req_valid[r] = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (req_ready[r]) got = 1'b1;
      n++;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL send_timeout: requester %0d never got ready", r);
    end
    @(posedge clk);
    #1;
    req_valid[r] = 1'b0;
    check("latency_valid", 64'(rsp_valid), 64'd1);
  endtask

  task automatic load_contend_payload();
    req_ctrl[0] = 3'b000; req_imm[0] = 25'h0002000; req_tag[0] = 5'h10;
    req_ctrl[1] = 3'b100; req_imm[1] = 25'h0000020; req_tag[1] = 5'h11;
  endtask

  // main sequence
  initial begin
    int n;
    total = 0; bad = 0; mon_en = 1'b1;
    arst_n = 1'b1; flush = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_ctrl = '0; req_imm = '0; req_tag = '0;
    #1 arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_cnt", 64'(conflict_cnt), 64'd0);
    req_valid = 2'b11;
    #1;
    check("reset_req_ready", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    @(negedge clk);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // single-requester vectors, one per format
    send(1'b0, 3'b000, 25'h1FFE000, 5'h01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send(1'b1, 3'b100, 25'h1000000, 5'h0A, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(1'b0, 3'b001, 25'h0040005, 5'h02, 64'h0000_0000_0000_0025, 1'b0);
    send(1'b1, 3'b010, 25'h1000002, 5'h03, 64'hFFFF_FFFF_FFFF_F002, 1'b0);
    send(1'b0, 3'b011, 25'h0006020, 5'h04, 64'h0000_0000_0000_1802, 1'b0);
    send(1'b1, 3'b101, 25'h1234567, 5'h05, 64'h0, 1'b1);
    check("cnt_no_contention", 64'(conflict_cnt), 64'd0);

    // contention, always-ready consumer: 0,1,0,1,0,1
    load_contend_payload();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pack_rsp(1'b0, 5'h10, 64'h1, 1'b0));
      exp_q.push_back(pack_rsp(1'b1, 5'h11, 64'h1000, 1'b0));
    end
    req_valid = 2'b11;
    repeat (6) @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("cnt_after_contention", 64'(conflict_cnt), 64'd6);
    @(posedge clk);
    #1;

    // stall with both valid: outputs frozen, then grant moves to id 1
    rsp_ready = 1'b0;
    exp_q.push_back(pack_rsp(1'b0, 5'h10, 64'h1, 1'b0));
    exp_q.push_back(pack_rsp(1'b1, 5'h11, 64'h1000, 1'b0));
    req_valid = 2'b11;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check("stall_rsp_id", 64'(rsp_id), 64'd0);
      check("stall_rsp_imm", rsp_imm, 64'h1);
      check("stall_rsp_tag", 64'(rsp_tag), 64'h10);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rr_after_stall", 64'(req_ready), 64'b10);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("cnt_after_stall", 64'(conflict_cnt), 64'd8);
    @(posedge clk);
    #1;

    // flush while full and stalled: slot empties, no grant that cycle
    rsp_ready = 1'b0;
    send(1'b0, 3'b011, 25'h0006020, 5'h06, 64'h1802, 1'b0);
    load_contend_payload();
    req_valid[1] = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_req_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    req_valid = 2'b00;
    check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
    check("flush_cnt_kept", 64'(conflict_cnt), 64'd8);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;

    // asynchronous reset mid-stream
    mon_en = 1'b0;
    load_contend_payload();
    req_valid = 2'b11;
    @(posedge clk);
    @(posedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("arst_rsp_imm", rsp_imm, 64'd0);
    check("arst_rsp_id", 64'(rsp_id), 64'd0);
    check("arst_rsp_tag", 64'(rsp_tag), 64'd0);
    check("arst_rsp_err", 64'(rsp_err), 64'd0);
    check("arst_cnt", 64'(conflict_cnt), 64'd0);
    check("arst_req_ready", 64'(req_ready), 64'd0);
    req_valid = 2'b00;
    exp_q.delete();
    @(negedge clk);
    arst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(pack_rsp(1'b0, 5'h10, 64'h1, 1'b0));
    exp_q.push_back(pack_rsp(1'b1, 5'h11, 64'h1000, 1'b0));
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 2'b00;
    check("cnt_after_reset", 64'(conflict_cnt), 64'd2);

    // drain scoreboard (bounded)
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
